// File: rtl/mul_pkg.sv
// mul_pkg: op encodings and FSM state encoding shared by the sequential multiplier.
package mul_pkg;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MLA   = 2'b01,
    OP_UMULL = 2'b10,
    OP_SMULL = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: conditional two's-complement negate of a W-bit value.
module mul_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: radix-2 shift-add multiplier (MUL/MLA/UMULL/SMULL), IDLE->CALC->FIX->DONE.
// Define MUL_SEQ_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are zero.
module mul_seq_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t               r_state, w_next;
  op_t                  r_op;
  logic                 r_sign;
  logic [2*WIDTH-1:0]   r_mcand, r_prod;
  logic [WIDTH-1:0]     r_mplier, r_acc;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_mplier_nxt, w_lo, w_hi;
  logic [2*WIDTH-1:0]   w_prod_nxt, w_fixed;
  logic                 w_last, w_wide;
  mul_sign_fix #(.W(WIDTH)) u_fix_a (
    .i_val(a), .i_neg((op == OP_SMULL) && a[WIDTH-1]), .o_val(w_abs_a)
  );
  mul_sign_fix #(.W(WIDTH)) u_fix_b (
    .i_val(b), .i_neg((op == OP_SMULL) && b[WIDTH-1]), .o_val(w_abs_b)
  );
  mul_sign_fix #(.W(2*WIDTH)) u_fix_p (
    .i_val(r_prod), .i_neg(r_sign), .o_val(w_fixed)
  );
  assign w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_nxt = r_mplier >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif
  assign w_wide = (r_op == OP_UMULL) || (r_op == OP_SMULL);
  assign w_lo   = (r_op == OP_MLA) ? w_fixed[WIDTH-1:0] + r_acc : w_fixed[WIDTH-1:0];
  assign w_hi   = w_wide ? w_fixed[2*WIDTH-1:WIDTH] : '0;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (start ? S_CALC : S_IDLE) :
             (r_state == S_CALC) ? (w_last ? S_FIX : S_CALC) :
             (r_state == S_FIX)  ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_MUL;
      r_sign    <= 1'b0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_op     <= op_t'(op);
        r_sign   <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
        r_mplier <= w_abs_b;
        r_acc    <= acc;
        r_prod   <= '0;
        r_cnt    <= '0;
      end
      if (r_state == S_CALC) begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= w_mplier_nxt;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (r_state == S_FIX) begin
        result_lo <= w_lo;
        result_hi <= w_hi;
        flags     <= {w_wide ? w_hi[WIDTH-1] : w_lo[WIDTH-1], ~|{w_hi, w_lo}};
      end
    end
  end
endmodule
